// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scanner: FSM states, key-code table and key classes.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    HOLD,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    DIGIT,
    ENTER,
    CLEAR
  } key_class_t;

  // Codes 0-9 are the digits; A-D are 10-13, '*' is 14 and '#' is 15.
  localparam logic [3:0] KEY_CODE [4][4] = '{
    '{4'd1,  4'd2, 4'd3,  4'd10},
    '{4'd4,  4'd5, 4'd6,  4'd11},
    '{4'd7,  4'd8, 4'd9,  4'd12},
    '{4'd14, 4'd0, 4'd15, 4'd13}
  };

  function automatic key_class_t key_class(input logic [3:0] code);
    key_class_t cls;
    if (code <= 4'd9)       cls = DIGIT;
    else if (code == 4'd15) cls = ENTER;
    else if (code == 4'd14) cls = CLEAR;
    else                    cls = NONE;
    return cls;
  endfunction

  function automatic logic [1:0] low_row_idx(input logic [3:0] low);
    logic [1:0] idx;
    case (low)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module keypad_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_async,
  output logic [3:0] o_sync
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 4'b1111;
      r_sync <= 4'b1111;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce and one pulse per key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       equals,
  output logic       clear
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  state_t           r_state;
  logic [1:0]       r_col;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_row_pat;
  logic [3:0]       r_key;
  logic [3:0]       r_digit;
  logic             r_digit_valid;
  logic             r_equals;
  logic             r_clear;

  logic [3:0] w_rows;
  logic [3:0] w_low;
  logic       w_any_low;
  logic       w_one_low;

  keypad_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (row_in),
    .o_sync  (w_rows)
  );

  assign w_low     = ~w_rows;
  assign w_any_low = |w_low;
  assign w_one_low = w_any_low && ((w_low & (w_low - 4'd1)) == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= SCAN;
      r_col         <= 2'd0;
      r_div         <= '0;
      r_cnt         <= '0;
      r_digit       <= 4'd0;
      r_digit_valid <= 1'b0;
      r_equals      <= 1'b0;
      r_clear       <= 1'b0;
    end else begin
      r_digit_valid <= 1'b0;
      r_equals      <= 1'b0;
      r_clear       <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (!w_any_low) begin
              r_col <= r_col + 2'd1;
            end else if (w_one_low) begin
              r_row_pat <= w_rows;
              r_key     <= KEY_CODE[low_row_idx(w_low)][r_col];
              r_cnt     <= '0;
              r_state   <= DEBOUNCE;
            end else begin
              // Multiple rows low is ambiguous (ghosting); wait it out silently.
              r_state <= HOLD;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (w_rows == r_row_pat) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= EMIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_col   <= r_col + 2'd1;
            r_div   <= '0;
            r_state <= SCAN;
          end
        end
        EMIT: begin
          case (key_class(r_key))
            DIGIT: begin
              r_digit       <= r_key;
              r_digit_valid <= 1'b1;
            end
            ENTER:   r_equals <= 1'b1;
            CLEAR:   r_clear  <= 1'b1;
            default: ;
          endcase
          r_state <= HOLD;
        end
        HOLD: begin
          if (w_rows == 4'hF) begin
            r_cnt   <= '0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          if (w_rows == 4'hF) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_col   <= r_col + 2'd1;
              r_div   <= '0;
              r_state <= SCAN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_state <= HOLD;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign col_out     = ~(4'b0001 << r_col);
  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign equals      = r_equals;
  assign clear       = r_clear;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] digit;
  logic       digit_valid;
  logic       equals;
  logic       clear;

  logic [15:0] keys = 16'h0;

  int n_tests = 0;
  int n_fail  = 0;

  int n_dv = 0;
  int n_eq = 0;
  int n_clr = 0;
  int n_both = 0;
  int n_eq_unstable = 0;
  logic [3:0] prev_digit = 4'd0;
  logic [3:0] lock_buf [16];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row_in      (row_in),
    .col_out     (col_out),
    .digit       (digit),
    .digit_valid (digit_valid),
    .equals      (equals),
    .clear       (clear)
  );

  // Key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (digit_valid) n_dv++;
    if (equals) begin
      if (n_eq < 16) lock_buf[n_eq] = digit;
      n_eq++;
      if (digit !== prev_digit) n_eq_unstable++;
    end
    if (clear) n_clr++;
    if (digit_valid && equals) n_both++;
    prev_digit = digit;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input int r, input int c, input int hold);
    keys[r*4+c] = 1'b1;
    cyc(hold);
    keys[r*4+c] = 1'b0;
    cyc(24);
  endtask

  task automatic wait_col(input logic [3:0] want, input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      cyc(1);
      if (col_out == want) found = 1'b1;
    end
  endtask

  task automatic digit_pos(input int d, output int r, output int c);
    if (d == 0) begin
      r = 3; c = 1;
    end else begin
      r = (d - 1) / 3; c = (d - 1) % 3;
    end
  endtask

  initial begin
    int d0, e0, c0, r, c;
    bit found, lock_ok;
    int code [8] = '{3, 9, 0, 0, 8, 1, 2, 1};

    reset = 1'b1;
    cyc(3);
    check("rst_col", col_out, 4'b1110);
    check("rst_digit", digit, 0);
    check("rst_dv", digit_valid, 0);
    check("rst_eq", equals, 0);
    check("rst_clr", clear, 0);
    reset = 1'b0;
    cyc(2);

    // Press '3' and hold
    d0 = n_dv;
    keys[0*4+2] = 1'b1;
    cyc(40);
    check("hold3_col", col_out, 4'b1011);
    check("hold3_digit", digit, 3);
    check("hold3_dv", n_dv - d0, 1);
    keys[0*4+2] = 1'b0;
    cyc(24);
    check("hold3_norepeat", n_dv - d0, 1);

    // '#' after 3
    d0 = n_dv; e0 = n_eq;
    press(3, 2, 40);
    check("hash_eq", n_eq - e0, 1);
    check("hash_digit", digit, 3);
    check("hash_dv", n_dv - d0, 0);

    // Bounce on '5'
    d0 = n_dv; e0 = n_eq; c0 = n_clr;
    wait_col(4'b1101, 40, found);
    check("bounce_find_col1", found, 1);
    keys[1*4+1] = 1'b1;
    cyc(3);
    keys[1*4+1] = 1'b0;
    cyc(4);
    check("bounce_col", col_out, 4'b1011);
    cyc(20);
    check("bounce_pulses", (n_dv - d0) + (n_eq - e0) + (n_clr - c0), 0);

    // Two rows low on column 0
    d0 = n_dv; e0 = n_eq; c0 = n_clr;
    keys[0*4+0] = 1'b1;
    keys[1*4+0] = 1'b1;
    cyc(40);
    check("multi_col", col_out, 4'b1110);
    check("multi_pulses", (n_dv - d0) + (n_eq - e0) + (n_clr - c0), 0);
    keys[0*4+0] = 1'b0;
    keys[1*4+0] = 1'b0;
    wait_col(4'b1101, 40, found);
    check("multi_resume", found, 1);

    // Lock code entry
    e0 = n_eq;
    for (int i = 0; i < 8; i++) begin
      digit_pos(code[i], r, c);
      press(r, c, 40);
      press(3, 2, 40);
    end
    check("lock_eq_count", n_eq - e0, 8);
    lock_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("lock_digit", lock_buf[(e0 + i) % 16], code[i]);
      if (lock_buf[(e0 + i) % 16] != 4'(code[i])) lock_ok = 1'b0;
    end
    check("lock_ok", lock_ok, 1);
    c0 = n_clr;
    press(3, 0, 40);
    check("star_clr", n_clr - c0, 1);
    check("star_digit", digit, 1);

    // Reset while debouncing '7'
    reset = 1'b1;
    cyc(2);
    d0 = n_dv; e0 = n_eq; c0 = n_clr;
    reset = 1'b0;
    keys[2*4+0] = 1'b1;
    cyc(6);
    reset = 1'b1;
    cyc(1);
    keys[2*4+0] = 1'b0;
    check("rstdb_col", col_out, 4'b1110);
    check("rstdb_digit", digit, 0);
    check("rstdb_outs", {digit_valid, equals, clear}, 0);
    cyc(1);
    reset = 1'b0;
    cyc(30);
    check("rstdb_pulses", (n_dv - d0) + (n_eq - e0) + (n_clr - c0), 0);
    check("rstdb_digit_after", digit, 0);

    check("eq_dv_overlap", n_both, 0);
    check("eq_digit_stable", n_eq_unstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
